// File: rtl/lw_sha_pkg.sv
// Shared SHA/HMAC definitions: algorithm encodings and per-algorithm digest
// geometry (word count and bytes used in the final word) for S64 and S32 cores.
package lw_sha_pkg;

  typedef enum logic [2:0] {
    ALGO_SHA256     = 3'd0,
    ALGO_SHA224     = 3'd1,
    ALGO_SHA512     = 3'd2,
    ALGO_SHA384     = 3'd3,
    ALGO_SHA512_256 = 3'd4,
    ALGO_SHA512_224 = 3'd5,
    ALGO_RSVD6      = 3'd6,
    ALGO_RSVD7      = 3'd7
  } algo_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } unload_state_e;

  // First index selects the core build: 0 = S64, 1 = S32 (only codes 0/1 exist).
  localparam logic [3:0] DIGEST_WORDS [2][8] = '{
    '{4'd4, 4'd4, 4'd8, 4'd6, 4'd4, 4'd4, 4'd0, 4'd0},
    '{4'd8, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}
  };

  localparam logic [3:0] LAST_BYTES [2][8] = '{
    '{4'd8, 4'd4, 4'd8, 4'd8, 4'd8, 4'd4, 4'd0, 4'd0},
    '{4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}
  };

  function automatic logic algo_invalid(input algo_e algo, input logic is_s32);
    if (is_s32) return (algo > ALGO_SHA224);
    return (algo == ALGO_RSVD6) || (algo == ALGO_RSVD7);
  endfunction

endpackage

// File: rtl/lw_edge_rise.sv
// Rising-edge detector for level-held status strobes, synchronous active-high reset.
module lw_edge_rise (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is always written with <= so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset_i) level_q <= 1'b0;
    else         level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/lw_digest_unloader.sv
// Captures the engine digest bank on the rise of done and streams the words used
// by the active algorithm. Optional LW_DIGEST_ZEROIZE_EN scrubs sent/aborted words.
module lw_digest_unloader
  import lw_sha_pkg::*;
#(
  parameter int WORD_W = 64,
  parameter int OPC_W  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [OPC_W-1:0]       opcode_i,
  input  logic                   abort_i,
  input  logic [7:0][WORD_W-1:0] hash_i,
  input  logic                   done_i,
  output logic [WORD_W-1:0]      dout_o,
  output logic                   dout_valid_o,
  input  logic                   dout_ready_i,
  output logic                   dout_last_o,
  output logic [3:0]             dout_bytes_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam logic       IS_S32         = (WORD_W == 32);
  localparam logic [3:0] BYTES_PER_WORD = 4'(WORD_W / 8);

  unload_state_e       state_q, state_d;
  algo_e               algo_q;
  logic [WORD_W-1:0]   buf_q [8];
  logic [2:0]          idx_q;
  logic [3:0]          words_left_q;
  logic                overrun_q;
  logic                done_rise;
  logic                xfer;
  logic                capture;
  logic [2:0]          opc_algo;
  logic                unused_hmac;
  logic                valid_w;
  logic                last_w;
  logic [3:0]          bytes_w;
  logic [WORD_W-1:0]   word_w;

  lw_edge_rise u_done_rise (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .level_i (done_i),
    .rise_o  (done_rise)
  );

  // The top opcode bit is the HMAC flag; the bits below it select the algorithm.
  always_comb begin
    opc_algo = '0;
    for (int i = 0; i < OPC_W - 1 && i < 3; i++) opc_algo[i] = opcode_i[i];
  end
  assign unused_hmac = opcode_i[OPC_W-1];

  assign xfer    = valid_w & dout_ready_i;
  assign capture = (state_q == ST_IDLE) && done_rise && !abort_i &&
                   !algo_invalid(algo_q, IS_S32);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (capture) state_d = ST_STREAM;
      ST_STREAM: if (xfer && words_left_q == 4'd1) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_i) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      // NOTE: the digest buffer is reset explicitly; a reset must not leave
      // stale key-derived material readable on dout_o.
      for (int k = 0; k < 8; k++) buf_q[k] <= '0;
      idx_q        <= '0;
      words_left_q <= '0;
      algo_q       <= ALGO_SHA256;
      overrun_q    <= 1'b0;
    end else begin
      if (start_i && state_q == ST_IDLE) begin
        algo_q    <= algo_e'(opc_algo);
        overrun_q <= 1'b0;
      end
      if (abort_i) begin
        words_left_q <= '0;
`ifdef LW_DIGEST_ZEROIZE_EN
        for (int k = 0; k < 8; k++) buf_q[k] <= '0;
`endif
      end else if (capture) begin
        for (int k = 0; k < 8; k++) buf_q[k] <= hash_i[k];
        idx_q        <= 3'd7;
        words_left_q <= DIGEST_WORDS[IS_S32][algo_q];
      end else if (state_q == ST_STREAM) begin
        // A digest arriving mid-stream is dropped; the current stream wins.
        if (done_rise) overrun_q <= 1'b1;
        if (xfer) begin
          idx_q        <= idx_q - 3'd1;
          words_left_q <= words_left_q - 4'd1;
`ifdef LW_DIGEST_ZEROIZE_EN
          if (words_left_q == 4'd1) begin
            for (int k = 0; k < 8; k++) buf_q[k] <= '0;
          end else begin
            buf_q[idx_q] <= '0;
          end
`endif
        end
      end
    end
  end

  always_comb begin
    valid_w = (state_q == ST_STREAM);
    last_w  = valid_w && (words_left_q == 4'd1);
    bytes_w = '0;
    if (valid_w) bytes_w = last_w ? LAST_BYTES[IS_S32][algo_q] : BYTES_PER_WORD;
    word_w = buf_q[idx_q];
    // Partial final word: bytes are MSB-aligned, unused low bytes read as zero.
    for (int b = 0; b < WORD_W / 8; b++) begin
      if (last_w && b >= int'(bytes_w)) word_w[WORD_W-1-8*b -: 8] = '0;
    end
`ifdef LW_DIGEST_ZEROIZE_EN
    if (!valid_w) word_w = '0;
`endif
  end

  assign dout_o       = word_w;
  assign dout_valid_o = valid_w;
  assign dout_last_o  = last_w;
  assign dout_bytes_o = bytes_w;
  assign busy_o       = valid_w;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_lw_digest_unloader.sv
// Self-checking bench for lw_digest_unloader (S64 build) with a queue-based
// reference model of the expected word stream.
module tb_lw_digest_unloader;

  localparam int WORD_W = 64;
  localparam int OPC_W  = 4;

  logic                   clk_i = 1'b0;
  logic                   reset_i = 1'b1;
  logic                   start_i = 1'b0;
  logic [OPC_W-1:0]       opcode_i = '0;
  logic                   abort_i = 1'b0;
  logic [7:0][WORD_W-1:0] hash_i = '0;
  logic                   done_i = 1'b0;
  logic                   dout_ready_i = 1'b0;
  logic [WORD_W-1:0]      dout_o;
  logic                   dout_valid_o;
  logic                   dout_last_o;
  logic [3:0]             dout_bytes_o;
  logic                   busy_o;
  logic                   overrun_o;

  lw_digest_unloader #(.WORD_W(WORD_W), .OPC_W(OPC_W)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .opcode_i     (opcode_i),
    .abort_i      (abort_i),
    .hash_i       (hash_i),
    .done_i       (done_i),
    .dout_o       (dout_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_last_o  (dout_last_o),
    .dout_bytes_o (dout_bytes_o),
    .busy_o       (busy_o),
    .overrun_o    (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the digest geometry restated from the algorithm list.
  int tbl_words [8] = '{4, 4, 8, 6, 4, 4, 0, 0};
  int tbl_last  [8] = '{8, 4, 8, 8, 8, 4, 0, 0};

  typedef struct {
    logic [63:0] word;
    int          bytes;
  } exp_t;

  exp_t        exp_q [$];
  exp_t        m_e;
  logic        m_done_prev = 1'b0;
  logic        m_overrun   = 1'b0;
  int          m_algo      = 0;
  logic        m_rise;
  logic        m_busy;
  bit          mon_en      = 1'b0;
  int          xfer_count  = 0;
  logic [63:0] last_word_seen = '0;
  int          last_bytes_seen = 0;

  // Scoreboard: compares every cycle, then advances the model to the next edge.
  always @(negedge clk_i) begin
    if (reset_i) begin
      exp_q.delete();
      m_overrun   = 1'b0;
      m_algo      = 0;
      m_done_prev = 1'b0;
    end else if (mon_en) begin
      m_busy = (exp_q.size() > 0);
      n_checks++;
      if (dout_valid_o !== m_busy) begin
        n_fail++; $display("FAIL valid: got %b expected %b", dout_valid_o, m_busy);
      end
      n_checks++;
      if (busy_o !== m_busy) begin
        n_fail++; $display("FAIL busy: got %b expected %b", busy_o, m_busy);
      end
      n_checks++;
      if (overrun_o !== m_overrun) begin
        n_fail++; $display("FAIL overrun: got %b expected %b", overrun_o, m_overrun);
      end
      if (m_busy && dout_valid_o === 1'b1) begin
        n_checks++;
        if (dout_o !== exp_q[0].word) begin
          n_fail++; $display("FAIL dout: got %h expected %h", dout_o, exp_q[0].word);
        end
        n_checks++;
        if (dout_last_o !== (exp_q.size() == 1)) begin
          n_fail++; $display("FAIL last: got %b expected %b", dout_last_o, exp_q.size() == 1);
        end
        n_checks++;
        if (int'(dout_bytes_o) != exp_q[0].bytes) begin
          n_fail++; $display("FAIL bytes: got %0d expected %0d", dout_bytes_o, exp_q[0].bytes);
        end
        if (dout_ready_i && !abort_i) begin
          xfer_count++;
          if (dout_last_o) begin
            last_word_seen  = dout_o;
            last_bytes_seen = int'(dout_bytes_o);
          end
          void'(exp_q.pop_front());
        end
      end
`ifdef LW_DIGEST_ZEROIZE_EN
      if (dout_valid_o === 1'b0) begin
        n_checks++;
        if (dout_o !== '0) begin
          n_fail++; $display("FAIL idle_zero: got %h expected 0", dout_o);
        end
      end
`endif
      m_rise      = done_i && !m_done_prev;
      m_done_prev = done_i;
      if (abort_i) begin
        exp_q.delete();
      end else if (m_busy) begin
        if (m_rise) m_overrun = 1'b1;
      end else begin
        if (m_rise && m_algo < 6) begin
          for (int i = 0; i < tbl_words[m_algo]; i++) begin
            m_e.word  = hash_i[7-i];
            m_e.bytes = 8;
            if (i == tbl_words[m_algo] - 1) begin
              m_e.bytes = tbl_last[m_algo];
              if (m_e.bytes < 8) m_e.word &= ~((64'd1 << (8 * (8 - m_e.bytes))) - 64'd1);
            end
            exp_q.push_back(m_e);
          end
        end
        if (start_i) begin
          m_algo    = int'(opcode_i[2:0]);
          m_overrun = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [OPC_W-1:0] op);
    start_i  = 1'b1;
    opcode_i = op;
    done_i   = 1'b0;
    tick();
    start_i  = 1'b0;
    tick();
  endtask

  task automatic rand_hash();
    for (int k = 0; k < 8; k++) hash_i[k] = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy_o === 1'b1 && c < budget) begin
      tick();
      c++;
    end
    if (busy_o !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: still busy after %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    mon_en  = 1'b1;
    reset_i = 1'b0;
    n_checks++; if (dout_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", dout_valid_o); end
    n_checks++; if (dout_o !== '0) begin n_fail++; $display("FAIL rst_dout: got %h expected 0", dout_o); end
    n_checks++; if (dout_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b expected 0", dout_last_o); end
    n_checks++; if (dout_bytes_o !== 4'd0) begin n_fail++; $display("FAIL rst_bytes: got %0d expected 0", dout_bytes_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    n_checks++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun_o); end
  endtask

  task automatic test_sha512();
    int x0, cyc;
    dout_ready_i = 1'b1;
    do_start(4'd2);
    for (int k = 0; k < 8; k++) hash_i[k] = 64'h1111_1111_1111_1111 * 64'(k);
    x0 = xfer_count;
    done_i = 1'b1;
    tick();
    n_checks++;
    if (dout_valid_o !== 1'b1) begin n_fail++; $display("FAIL latency: valid %b expected 1", dout_valid_o); end
    cyc = 0;
    while (dout_valid_o === 1'b1 && cyc < 20) begin tick(); cyc++; end
    n_checks++;
    if (cyc != 8) begin n_fail++; $display("FAIL sha512_cycles: got %0d expected 8", cyc); end
    n_checks++;
    if (xfer_count - x0 != 8) begin n_fail++; $display("FAIL sha512_xfers: got %0d expected 8", xfer_count - x0); end
  endtask

  task automatic test_sha512_224();
    int x0;
    dout_ready_i = 1'b1;
    do_start(4'd5);
    rand_hash();
    hash_i[4] = 64'hAABBCCDD_EEFF0011;
    x0 = xfer_count;
    done_i = 1'b1;
    tick();
    wait_idle(20);
    n_checks++;
    if (xfer_count - x0 != 4) begin n_fail++; $display("FAIL s224_xfers: got %0d expected 4", xfer_count - x0); end
    n_checks++;
    if (last_word_seen !== 64'hAABBCCDD_00000000) begin
      n_fail++; $display("FAIL s224_last_word: got %h expected aabbccdd00000000", last_word_seen);
    end
    n_checks++;
    if (last_bytes_seen != 4) begin n_fail++; $display("FAIL s224_last_bytes: got %0d expected 4", last_bytes_seen); end
  endtask

  task automatic test_stall();
    int x0, i;
    logic [63:0] held;
    logic stalled;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_start(4'd3);
    rand_hash();
    x0 = xfer_count;
    dout_ready_i = 1'b0;
    done_i = 1'b1;
    tick();
    stalled = 1'b0;
    held    = '0;
    i       = 0;
    while (busy_o === 1'b1 && i < 60) begin
      if (stalled) begin
        n_checks++;
        if (dout_o !== held) begin n_fail++; $display("FAIL stall_stable: got %h expected %h", dout_o, held); end
      end
      dout_ready_i = pat[i % 4];
      held    = dout_o;
      stalled = dout_valid_o && !dout_ready_i;
      tick();
      i++;
    end
    n_checks++;
    if (xfer_count - x0 != 6) begin n_fail++; $display("FAIL stall_xfers: got %0d expected 6", xfer_count - x0); end
    dout_ready_i = 1'b1;
  endtask

  task automatic test_overrun();
    int x0;
    dout_ready_i = 1'b1;
    do_start(4'd2);
    rand_hash();
    x0 = xfer_count;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    tick();
    rand_hash();
    done_i = 1'b1;
    tick();
    n_checks++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b expected 1", overrun_o); end
    wait_idle(20);
    n_checks++;
    if (xfer_count - x0 != 8) begin n_fail++; $display("FAIL overrun_xfers: got %0d expected 8", xfer_count - x0); end
    n_checks++;
    if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b expected 1", overrun_o); end
    do_start(4'd2);
    n_checks++;
    if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b expected 0", overrun_o); end
  endtask

  task automatic test_abort();
    int x0;
    dout_ready_i = 1'b1;
    do_start(4'd2);
    rand_hash();
    done_i = 1'b1;
    tick();
    tick();
    tick();
    abort_i      = 1'b1;
    dout_ready_i = 1'b0;
    tick();
    abort_i = 1'b0;
    n_checks++;
    if (dout_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", dout_valid_o); end
`ifdef LW_DIGEST_ZEROIZE_EN
    n_checks++;
    if (dout_o !== '0) begin n_fail++; $display("FAIL abort_zero: got %h expected 0", dout_o); end
`endif
    dout_ready_i = 1'b1;
    do_start(4'd2);
    rand_hash();
    x0 = xfer_count;
    done_i = 1'b1;
    tick();
    wait_idle(20);
    n_checks++;
    if (xfer_count - x0 != 8) begin n_fail++; $display("FAIL abort_fresh: got %0d expected 8", xfer_count - x0); end
    // Rise coinciding with abort must capture nothing.
    do_start(4'd0);
    done_i  = 1'b1;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    tick();
    n_checks++;
    if (dout_valid_o !== 1'b0) begin n_fail++; $display("FAIL abort_rise: got %b expected 0", dout_valid_o); end
  endtask

  task automatic test_level_invalid();
    int x0;
    logic saw;
    dout_ready_i = 1'b1;
    do_start(4'd0);
    rand_hash();
    x0 = xfer_count;
    done_i = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (xfer_count - x0 != 4) begin n_fail++; $display("FAIL level_xfers: got %0d expected 4", xfer_count - x0); end
    do_start(4'd6);
    rand_hash();
    x0  = xfer_count;
    saw = 1'b0;
    done_i = 1'b1;
    repeat (10) begin tick(); saw |= dout_valid_o; end
    n_checks++;
    if (saw !== 1'b0) begin n_fail++; $display("FAIL invalid_valid: got %b expected 0", saw); end
    n_checks++;
    if (xfer_count - x0 != 0) begin n_fail++; $display("FAIL invalid_xfers: got %0d expected 0", xfer_count - x0); end
  endtask

  task automatic test_reset_mid();
    dout_ready_i = 1'b1;
    do_start(4'd2);
    rand_hash();
    done_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b1;
    done_i  = 1'b0;
    tick();
    n_checks++; if (dout_valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", dout_valid_o); end
    n_checks++; if (dout_o !== '0) begin n_fail++; $display("FAIL midrst_dout: got %h expected 0", dout_o); end
    n_checks++; if (dout_last_o !== 1'b0) begin n_fail++; $display("FAIL midrst_last: got %b expected 0", dout_last_o); end
    n_checks++; if (dout_bytes_o !== 4'd0) begin n_fail++; $display("FAIL midrst_bytes: got %0d expected 0", dout_bytes_o); end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int a, x0;
    for (int it = 0; it < 8; it++) begin
      a = $urandom_range(0, 5);
      do_start({1'($urandom_range(0, 1)), 3'(a)});
      rand_hash();
      x0 = xfer_count;
      done_i = 1'b1;
      dout_ready_i = 1'($urandom_range(0, 1));
      tick();
      for (int c = 0; c < 100 && busy_o === 1'b1; c++) begin
        dout_ready_i = 1'($urandom_range(0, 1));
        tick();
      end
      dout_ready_i = 1'b1;
      wait_idle(20);
      n_checks++;
      if (xfer_count - x0 != tbl_words[a]) begin
        n_fail++; $display("FAIL rand_xfers algo %0d: got %0d expected %0d", a, xfer_count - x0, tbl_words[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sha512();
    test_sha512_224();
    test_stall();
    test_overrun();
    test_abort();
    test_level_invalid();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
